// File: rtl/gticc_link_ctrl.sv
// Link bring-up and supervision controller for one 8b/10b GTX lane.
// Sequences the lane reset, qualifies alignment on a run of clean K28.5
// idle words, supervises the running link for word errors and retrains
// with a bounded number of retries.
module gticc_link_ctrl #(
  parameter int unsigned RESET_LEN     = 16,
  parameter int unsigned DONE_TIMEOUT  = 100000,
  parameter int unsigned LOCK_GOOD     = 64,
  parameter int unsigned ALIGN_TIMEOUT = 100000,
  parameter int unsigned ERR_WINDOW    = 1024,
  parameter int unsigned ERR_MAX       = 8,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        gt_resetdone,
  output logic        gt_reset,
  output logic        gt_readyforreset,
  input  logic [31:0] rxdata,
  input  logic [3:0]  rxcharisk,
  input  logic [31:0] user_txdata,
  input  logic [3:0]  user_txcharisk,
  output logic [31:0] txdata,
  output logic [3:0]  txcharisk,
  output logic        link_up,
  output logic        fail,
  output logic [2:0]  state,
  output logic [7:0]  retry_cnt,
  output logic [15:0] err_total
);

  localparam int unsigned TMR_W  = 24;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned K_W    = 4;

  localparam logic [DATA_W-1:0] IDLE_WORD = 32'h0000_00BC;
  localparam logic [K_W-1:0]    IDLE_K    = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_WAIT  = 3'd2,
    S_ALIGN = 3'd3,
    S_UP    = 3'd4,
    S_FAIL  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    lock_q, lock_d;
  logic [BYTE_W-1:0]   win_err_q, win_err_d;
  logic [BYTE_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]    err_tot_q, err_tot_d;
  logic                gt_reset_q, rdy_q, link_up_q, fail_q;
  logic [DATA_W-1:0]   txdata_q;
  logic [K_W-1:0]      txk_q;

  logic                is_idle, is_err, win_wrap, fail_ev;
  logic [BYTE_W-1:0]   win_err_nx;

  // Classify the received word and compute the error count for this cycle.
  assign is_idle    = (rxcharisk == IDLE_K) && (rxdata == IDLE_WORD);
  assign is_err     = ((rxcharisk != 4'b0000) && (rxcharisk != IDLE_K)) ||
                      ((rxcharisk == IDLE_K) && (rxdata[7:0] != 8'hBC));
  assign win_wrap   = (timer_q == TMR_W'(ERR_WINDOW - 1));
  // An error on the wrap cycle is the first error of the new window.
  assign win_err_nx = win_wrap ? BYTE_W'(is_err) : (win_err_q + BYTE_W'(is_err));

  // Next-state, timers and counters; enable=0 overrides everything.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lock_d    = lock_q;
    win_err_d = win_err_q;
    retry_d   = retry_q;
    err_tot_d = err_tot_q;
    fail_ev   = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (enable) state_d = S_RESET;
      end
      S_RESET: begin
        if (timer_q == TMR_W'(RESET_LEN - 1)) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT: begin
        if (gt_resetdone) begin
          state_d = S_ALIGN;
          timer_d = '0;
          lock_d  = '0;
        end else if (timer_q == TMR_W'(DONE_TIMEOUT - 1)) begin
          fail_ev = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ALIGN: begin
        timer_d = timer_q + TMR_W'(1);
        lock_d  = is_idle ? (lock_q + CNT_W'(1)) : '0;
        if (!gt_resetdone || (timer_q == TMR_W'(ALIGN_TIMEOUT - 1))) begin
          fail_ev = 1'b1;
        end else if (is_idle && (lock_q == CNT_W'(LOCK_GOOD - 1))) begin
          state_d   = S_UP;
          timer_d   = '0;
          win_err_d = '0;
          retry_d   = '0;
        end
      end
      S_UP: begin
        timer_d   = win_wrap ? '0 : (timer_q + TMR_W'(1));
        win_err_d = win_err_nx;
        if (is_err && (err_tot_q != 16'hFFFF)) err_tot_d = err_tot_q + CNT_W'(1);
        if (!gt_resetdone || (win_err_nx == BYTE_W'(ERR_MAX))) fail_ev = 1'b1;
      end
      S_FAIL: begin
        timer_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_ev) begin
      timer_d   = '0;
      lock_d    = '0;
      win_err_d = '0;
      if (retry_q == BYTE_W'(MAX_RETRY)) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + BYTE_W'(1);
        state_d = S_RESET;
      end
    end

    if (!enable) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      lock_d    = '0;
      win_err_d = '0;
      retry_d   = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      lock_q     <= '0;
      win_err_q  <= '0;
      retry_q    <= '0;
      err_tot_q  <= '0;
      gt_reset_q <= 1'b0;
      rdy_q      <= 1'b0;
      link_up_q  <= 1'b0;
      fail_q     <= 1'b0;
      txdata_q   <= IDLE_WORD;
      txk_q      <= IDLE_K;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lock_q     <= lock_d;
      win_err_q  <= win_err_d;
      retry_q    <= retry_d;
      err_tot_q  <= err_tot_d;
      gt_reset_q <= (state_d == S_RESET);
      rdy_q      <= (state_d != S_IDLE) && (state_d != S_FAIL);
      link_up_q  <= (state_d == S_UP);
      fail_q     <= (state_d == S_FAIL);
      txdata_q   <= (state_q == S_UP) ? user_txdata    : IDLE_WORD;
      txk_q      <= (state_q == S_UP) ? user_txcharisk : IDLE_K;
    end
  end

  assign state            = 3'(state_q);
  assign gt_reset         = gt_reset_q;
  assign gt_readyforreset = rdy_q;
  assign link_up          = link_up_q;
  assign fail             = fail_q;
  assign retry_cnt        = retry_q;
  assign err_total        = err_tot_q;
  assign txdata           = txdata_q;
  assign txcharisk        = txk_q;

endmodule

// File: tb/tb_gticc_link_ctrl.sv
// Directed bench for gticc_link_ctrl: bring-up, alignment disruption,
// error-window supervision, resetdone loss, abort and retry exhaustion.
module tb_gticc_link_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        gt_resetdone = 1'b0;
  logic        gt_reset, gt_readyforreset;
  logic [31:0] rxdata = 32'h0000_00BC;
  logic [3:0]  rxcharisk = 4'b0001;
  logic [31:0] user_txdata = 32'hCAFE_F00D;
  logic [3:0]  user_txcharisk = 4'b0000;
  logic [31:0] txdata;
  logic [3:0]  txcharisk;
  logic        link_up, fail;
  logic [2:0]  state;
  logic [7:0]  retry_cnt;
  logic [15:0] err_total;

  int n_cmp = 0;
  int n_bad = 0;
  int wpos  = 0;
  int cnt;
  int pulses;
  logic prev;

  // Error words: K flags in bits [35:32], data in [31:0].
  logic [35:0] err_vec [7] = '{
    {4'b0010, 32'h0000_0000},
    {4'b0001, 32'h0000_00AA},
    {4'b1111, 32'hBCBC_BCBC},
    {4'b0100, 32'h0000_BC00},
    {4'b0011, 32'h0000_00BC},
    {4'b1000, 32'hFFFF_FFFF},
    {4'b0001, 32'hBC00_00BD}
  };

  always #5 clk = ~clk;

  gticc_link_ctrl #(
    .RESET_LEN    (16),
    .DONE_TIMEOUT (100),
    .LOCK_GOOD    (64),
    .ALIGN_TIMEOUT(1000),
    .ERR_WINDOW   (1024),
    .ERR_MAX      (8),
    .MAX_RETRY    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .gt_resetdone    (gt_resetdone),
    .gt_reset        (gt_reset),
    .gt_readyforreset(gt_readyforreset),
    .rxdata          (rxdata),
    .rxcharisk       (rxcharisk),
    .user_txdata     (user_txdata),
    .user_txcharisk  (user_txcharisk),
    .txdata          (txdata),
    .txcharisk       (txcharisk),
    .link_up         (link_up),
    .fail            (fail),
    .state           (state),
    .retry_cnt       (retry_cnt),
    .err_total       (err_total)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic up_step(input logic [31:0] d, input logic [3:0] k);
    rxdata    = d;
    rxcharisk = k;
    tick();
    wpos = (wpos + 1) % 1024;
  endtask

  task automatic set_idle();
    rxdata    = 32'h0000_00BC;
    rxcharisk = 4'b0001;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_state",   32'(state), 32'd0);
    check("rst_gtreset", 32'(gt_reset), 32'd0);
    check("rst_rdy",     32'(gt_readyforreset), 32'd0);
    check("rst_linkup",  32'(link_up), 32'd0);
    check("rst_fail",    32'(fail), 32'd0);
    check("rst_retry",   32'(retry_cnt), 32'd0);
    check("rst_errtot",  32'(err_total), 32'd0);
    check("rst_txdata",  txdata, 32'h0000_00BC);
    check("rst_txk",     32'(txcharisk), 32'd1);
    reset = 1'b0;
    tick();

    // Clean bring-up
    enable = 1'b1;
    tick();
    check("bu_state_reset", 32'(state), 32'd1);
    check("bu_rdy", 32'(gt_readyforreset), 32'd1);
    cnt = 0;
    while (gt_reset === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("bu_reset_len", 32'(cnt), 32'd16);
    check("bu_state_wait", 32'(state), 32'd2);
    repeat (50) tick();
    gt_resetdone = 1'b1;
    tick();
    check("bu_state_align", 32'(state), 32'd3);
    cnt = 0;
    while (link_up !== 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check("bu_lock_cycles", 32'(cnt), 32'd64);
    check("bu_state_up", 32'(state), 32'd4);
    check("bu_retry", 32'(retry_cnt), 32'd0);
    check("bu_tx_still_idle", txdata, 32'h0000_00BC);
    wpos = 0;
    up_step(32'h0000_00BC, 4'b0001);
    check("bu_tx_user", txdata, 32'hCAFE_F00D);
    check("bu_txk_user", 32'(txcharisk), 32'd0);

    // Error window: seven errors plus two non-error data words
    for (int i = 0; i < 7; i++) up_step(err_vec[i][31:0], err_vec[i][35:32]);
    up_step(32'hDEAD_BEEF, 4'b0000);
    up_step(32'h1234_56BC, 4'b0001);
    check("ew_errtot_w1", 32'(err_total), 32'd7);
    check("ew_linkup_w1", 32'(link_up), 32'd1);
    while (wpos != 1023) up_step(32'h0000_00BC, 4'b0001);
    // Error on the wrap cycle belongs to the new window
    up_step(err_vec[0][31:0], err_vec[0][35:32]);
    check("ew_errtot_wrap", 32'(err_total), 32'd8);
    check("ew_state_wrap", 32'(state), 32'd4);
    for (int i = 1; i < 7; i++) up_step(err_vec[i][31:0], err_vec[i][35:32]);
    check("ew_errtot_w2", 32'(err_total), 32'd14);
    check("ew_linkup_w2", 32'(link_up), 32'd1);
    up_step(err_vec[3][31:0], err_vec[3][35:32]);
    check("ew_linkup_drop", 32'(link_up), 32'd0);
    check("ew_state_reset", 32'(state), 32'd1);
    check("ew_retry", 32'(retry_cnt), 32'd1);
    check("ew_errtot_8th", 32'(err_total), 32'd15);
    set_idle();

    // Alignment disruption after 60 idles
    cnt = 0;
    while (state !== 3'd3 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("ad_state_align", 32'(state), 32'd3);
    repeat (60) tick();
    check("ad_no_link_60", 32'(link_up), 32'd0);
    rxdata    = 32'h1234_5678;
    rxcharisk = 4'b0000;
    tick();
    set_idle();
    check("ad_still_align", 32'(state), 32'd3);
    cnt = 0;
    while (link_up !== 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check("ad_lock_cycles", 32'(cnt), 32'd64);
    check("ad_retry_cleared", 32'(retry_cnt), 32'd0);
    check("ad_errtot_kept", 32'(err_total), 32'd15);

    // Resetdone loss for one cycle
    repeat (3) tick();
    gt_resetdone = 1'b0;
    tick();
    gt_resetdone = 1'b1;
    check("rl_linkup", 32'(link_up), 32'd0);
    check("rl_state", 32'(state), 32'd1);
    check("rl_retry", 32'(retry_cnt), 32'd1);

    // Abort on cycle 5 of RESET
    repeat (4) tick();
    check("ab_gtreset_c5", 32'(gt_reset), 32'd1);
    enable = 1'b0;
    tick();
    check("ab_gtreset", 32'(gt_reset), 32'd0);
    check("ab_state", 32'(state), 32'd0);
    check("ab_retry", 32'(retry_cnt), 32'd0);
    check("ab_rdy", 32'(gt_readyforreset), 32'd0);

    // Retry exhaustion with resetdone stuck low
    gt_resetdone = 1'b0;
    tick();
    enable = 1'b1;
    cnt    = 0;
    pulses = 0;
    prev   = 1'b0;
    while (fail !== 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
      if (gt_reset === 1'b1 && prev === 1'b0) pulses++;
      prev = gt_reset;
    end
    check("rx_cycles", 32'(cnt), 32'd349);
    check("rx_pulses", 32'(pulses), 32'd3);
    check("rx_state", 32'(state), 32'd5);
    check("rx_rdy", 32'(gt_readyforreset), 32'd0);
    check("rx_gtreset", 32'(gt_reset), 32'd0);
    check("rx_retry", 32'(retry_cnt), 32'd2);
    repeat (5) tick();
    check("rx_fail_hold", 32'(fail), 32'd1);
    enable = 1'b0;
    tick();
    check("rx_exit_state", 32'(state), 32'd0);
    check("rx_exit_fail", 32'(fail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
